// File: rtl/player_life_ctrl_pkg.sv
// Shared definitions for the player life/invincibility manager: state
// encodings, default parameters and a counter-width helper.
package player_life_ctrl_pkg;

  localparam int unsigned LIVES_W          = 3;
  localparam int unsigned DEF_INIT_LIVES   = 3;
  localparam int unsigned DEF_INV_FRAMES   = 120;
  localparam int unsigned DEF_BLINK_FRAMES = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ALIVE      = 2'd1,
    ST_INVINCIBLE = 2'd2,
    ST_DEAD       = 2'd3
  } life_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter advanced by frame ticks; done_o flags the tick
// that takes the count from 1 to 0.
module frame_countdown #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    done_o = tick_i && (cnt_q == W'(1));
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_life_ctrl.sv
// Player life and invincibility manager: turns the collision level into
// single hits, counts lives, runs the blinking post-hit window, flags game over.
module player_life_ctrl
  import player_life_ctrl_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = DEF_INIT_LIVES,
  parameter int unsigned INV_FRAMES   = DEF_INV_FRAMES,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               game_start,
  input  logic               collision,
  output logic [LIVES_W-1:0] lives,
  output logic               invincible,
  output logic               player_visible,
  output logic               hit_pulse,
  output logic               game_over
);

  localparam int unsigned        INV_W      = cnt_width(INV_FRAMES);
  localparam int unsigned        BLINK_W    = cnt_width(BLINK_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INV_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_FRAMES);

  life_state_t        state_q;
  logic [LIVES_W-1:0] lives_q;
  logic               inv_q, vis_q, hit_q, over_q;

  logic tick_inv, hit, inv_load, inv_done, blink_done, blink_load, blink_clear;

  // Ticks only count while already invincible, so a tick in the hit cycle is dropped.
  always_comb begin
    tick_inv    = (state_q == ST_INVINCIBLE) && frame_tick && !game_start;
    hit         = (state_q == ST_ALIVE) && collision && !game_start;
    inv_load    = hit && (lives_q > LIVES_W'(1));
    blink_load  = inv_load || blink_done;
    blink_clear = game_start || inv_done;
  end

  frame_countdown #(.W(INV_W)) u_inv_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (game_start),
    .load_i    (inv_load),
    .load_val_i(INV_LOAD),
    .tick_i    (tick_inv),
    .done_o    (inv_done)
  );

  frame_countdown #(.W(BLINK_W)) u_blink_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (blink_clear),
    .load_i    (blink_load),
    .load_val_i(BLINK_LOAD),
    .tick_i    (tick_inv),
    .done_o    (blink_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lives_q <= LIVES_INIT;
      inv_q   <= 1'b0;
      vis_q   <= 1'b1;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (game_start) begin
        state_q <= ST_ALIVE;
        lives_q <= LIVES_INIT;
        inv_q   <= 1'b0;
        vis_q   <= 1'b1;
        over_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ALIVE: begin
            if (hit) begin
              hit_q <= 1'b1;
              if (lives_q > LIVES_W'(1)) begin
                lives_q <= lives_q - LIVES_W'(1);
                state_q <= ST_INVINCIBLE;
                inv_q   <= 1'b1;
              end else begin
                lives_q <= '0;
                state_q <= ST_DEAD;
                over_q  <= 1'b1;
                vis_q   <= 1'b0;
              end
            end
          end
          // Window exit wins over a coincident blink toggle.
          ST_INVINCIBLE: begin
            if (inv_done) begin
              state_q <= ST_ALIVE;
              inv_q   <= 1'b0;
              vis_q   <= 1'b1;
            end else if (blink_done) begin
              vis_q <= ~vis_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lives          = lives_q;
  assign invincible     = inv_q;
  assign player_visible = vis_q;
  assign hit_pulse      = hit_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed bench for player_life_ctrl (INIT_LIVES=3, INV_FRAMES=6, BLINK_FRAMES=2).
module tb_player_life_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_start = 1'b0;
  logic       collision = 1'b0;
  logic [2:0] lives;
  logic       invincible, player_visible, hit_pulse, game_over;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit s, c, t;
    int l, inv, vis, hit, over;
  } vec_t;

  vec_t tbl[13];
  int   hits, tk, pulses;
  bit   pre, t, expect_hit;

  always #5 clk = ~clk;

  player_life_ctrl #(
    .INIT_LIVES  (3),
    .INV_FRAMES  (6),
    .BLINK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .game_start    (game_start),
    .collision     (collision),
    .lives         (lives),
    .invincible    (invincible),
    .player_visible(player_visible),
    .hit_pulse     (hit_pulse),
    .game_over     (game_over)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int l, input int inv,
                         input int vis, input int hit, input int over);
    chk({tag, ".lives"}, int'(lives), l);
    chk({tag, ".invincible"}, int'(invincible), inv);
    chk({tag, ".visible"}, int'(player_visible), vis);
    chk({tag, ".hit_pulse"}, int'(hit_pulse), hit);
    chk({tag, ".game_over"}, int'(game_over), over);
  endtask

  task automatic step(input bit s, input bit c, input bit tk_in);
    game_start = s;
    collision  = c;
    frame_tick = tk_in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             s  c  t  lives inv vis hit over
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3, 0, 1, 0, 0};  // start
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2, 1, 1, 1, 0};  // hit, coincident tick dropped
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2, 1, 1, 0, 0};  // masked collision
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2, 1, 1, 0, 0};  // tick 1
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2, 1, 0, 0, 0};  // tick 2 toggle
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2, 1, 0, 0, 0};  // tick 3
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2, 1, 1, 0, 0};  // tick 4 toggle
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2, 1, 1, 0, 0};  // tick 5
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1, 0, 0};  // tick 6 exit, forced visible
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 0};  // rehit in ALIVE
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3, 0, 1, 0, 0};  // restart from INVINCIBLE
    tbl[11] = '{1'b1, 1'b1, 1'b0, 3, 0, 1, 0, 0};  // start beats hit
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2, 1, 1, 1, 0};  // plain hit

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 3, 0, 1, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].s, tbl[i].c, tbl[i].t);
      chk_all($sformatf("vec%0d", i), tbl[i].l, tbl[i].inv, tbl[i].vis,
              tbl[i].hit, tbl[i].over);
    end

    // Held collision: one hit per window, rehit right after each window.
    step(1'b1, 1'b0, 1'b0);
    hits = 0;
    tk = 0;
    expect_hit = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      t   = (cyc % 10 == 9);
      pre = invincible;
      step(1'b0, 1'b1, t);
      if (expect_hit) begin
        chk("rehit_next_cycle", int'(hit_pulse), 1);
        expect_hit = 1'b0;
      end
      if (hit_pulse) begin
        hits++;
        chk($sformatf("held_hit%0d.lives", hits), int'(lives), 3 - hits);
      end
      if (pre && t) tk++;
      if (pre && !invincible) begin
        chk("window_ticks", tk, 6);
        tk = 0;
        expect_hit = 1'b1;
      end
    end
    chk("held_hits", hits, 3);
    chk_all("dead", 0, 0, 0, 0, 1);

    pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1'b0, 1'b1, cyc[0]);
      if (hit_pulse) pulses++;
    end
    chk("dead_pulses", pulses, 0);
    chk_all("dead_hold", 0, 0, 0, 0, 1);

    step(1'b1, 1'b0, 1'b0);
    chk_all("restart_dead", 3, 0, 1, 0, 0);

    // Async reset in the middle of a window (counter at 3).
    step(1'b0, 1'b1, 1'b0);
    chk_all("pre_rst_hit", 2, 1, 1, 1, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_all("pre_rst_mid", 2, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 3, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_all($sformatf("idle%0d", i), 3, 0, 1, 0, 0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk_all("idle_start", 3, 0, 1, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("after_start_hit", 2, 1, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
